// File: rtl/addsub_result_buffer_pkg.sv
// Shared definitions for the add/sub result buffer: flag bit positions
// and the saturation limit of the 8-bit event counters.
package addsub_result_buffer_pkg;

  localparam int FLG_COUT     = 0;
  localparam int FLG_OVF      = 1;
  localparam int FLG_BORROW   = 2;
  localparam int FLG_VALIDITY = 3;

  localparam logic [7:0] SAT_MAX = 8'hFF;

  function automatic logic [3:0] packFlags(input logic cout, input logic ovf,
                                           input logic borrow, input logic validity);
    logic [3:0] flags;
    flags               = '0;
    flags[FLG_COUT]     = cout;
    flags[FLG_OVF]      = ovf;
    flags[FLG_BORROW]   = borrow;
    flags[FLG_VALIDITY] = validity;
    return flags;
  endfunction

endpackage

// File: rtl/addsub_result_buffer_sat_counter8.sv
// 8-bit event counter that sticks at its maximum instead of wrapping.
module sat_counter8
  import addsub_result_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != SAT_MAX)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/addsub_result_buffer.sv
// First-word-fall-through FIFO for adder/subtractor results with their
// status flags, plus saturating counts of overflowed and invalid results.
module addsub_result_buffer
  import addsub_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_cout,
  input  logic                     in_ovf,
  input  logic                     in_borrow,
  input  logic                     in_validity,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               ovf_count,
  output logic [7:0]               inv_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH+3:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_inFlags;

  assign in_ready  = (r_count != FULL_COUNT) && !clear;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  // A pop during clear is discarded along with everything else.
  assign w_pop     = out_valid && out_ready && !clear;
  assign w_inFlags = packFlags(in_cout, in_ovf, in_borrow, in_validity);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately unreset; the pointers alone define what is held.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_inFlags, in_result};
  end

  assign out_result = r_mem[r_rptr][WIDTH-1:0];
  assign out_flags  = r_mem[r_rptr][WIDTH+3:WIDTH];
  assign count      = r_count;

  sat_counter8 u_ovfCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (w_push && in_ovf),
    .count (ovf_count)
  );

  sat_counter8 u_invCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (w_push && !in_validity),
    .count (inv_count)
  );

endmodule
